wb_stream_sink: RTL and testbench
=================================

Name: wb_stream_sink

Overview:
- Wishbone B4 classic device that buffers bytes written by a controller into a FIFO.
- Drains the FIFO onto a valid/ready stream.
- Sits directly downstream of a wishbone_classic controller.
- Reads return FIFO occupancy; full FIFO produces retry responses, so software back-pressure is bus-visible.

Parameters:
- DAT_WIDTH, 8, Wishbone and stream data width in bits.
- DEPTH, 16, FIFO entries; power of two, >= 2, DEPTH < 2**DAT_WIDTH.
- ALLOW_READ, 1, 1: read cycles return occupancy with ack; 0: read cycles terminate with err.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- wb_cyc_i  input  1  Wishbone cycle.
- wb_stb_i  input  1  Wishbone strobe.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_dat_i  input  DAT_WIDTH  write data.
- wb_dat_o  output  DAT_WIDTH  read data.
- wb_ack_o  output  1  normal termination.
- wb_err_o  output  1  error termination.
- wb_rty_o  output  1  retry termination.
- m_valid_o  output  1  stream data valid.
- m_data_o  output  DAT_WIDTH  stream data (FIFO head).
- m_ready_i  input  1  stream consumer ready.
- count_o  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM = IDLE.
  - wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o = 0.
  - Pointers and count = 0; m_valid_o = 0.
  - Reset mid-transfer discards any pending response and all FIFO contents.
- request = wb_cyc_i && wb_stb_i.
- FSM IDLE:
  - All response outputs 0; wb_dat_o = 0.
  - On an edge with request high: go to RESP, registering exactly one of ack/err/rty plus wb_dat_o for the next cycle.
- FSM RESP:
  - Exactly one response line high for exactly one cycle, then unconditionally back to IDLE.
  - Request is not sampled in RESP, so a controller holding stb after ack starts a new transfer sampled in the following IDLE cycle.
  - Minimum 2 cycles per transfer; latency request -> response = 1 cycle.
- Write decision, taken at the IDLE sampling edge using count at that edge:
  - count < DEPTH: push wb_dat_i at that edge; respond ack.
  - count == DEPTH: no push; respond rty.
  - No same-edge bypass: a pop on the same edge does not make room.
- Read decision:
  - ALLOW_READ=1: wb_dat_o = count sampled at the decision edge, zero-extended; ack.
  - ALLOW_READ=0: err, wb_dat_o = 0.
  - Reads never modify the FIFO.
- Responses are generated while cyc stays high. If cyc/stb drop while in RESP, the response cycle still occurs and any push already taken stands.
- Stream side:
  - m_valid_o = (count != 0); m_data_o = entry at read pointer, registered storage with no combinational path from wb_dat_i.
  - Pop on an edge with m_valid_o && m_ready_i.
  - m_data_o must stay stable while m_valid_o && !m_ready_i.
- Count update: count <= count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - count never exceeds DEPTH or underflows.
- Outputs wb_ack_o, wb_err_o, wb_rty_o are mutually exclusive and never high in two consecutive cycles.

Test Plan:
- Reset then single write 0xA5, m_ready_i=0 -> wb_ack_o high exactly 1 cycle after request; m_valid_o=1, m_data_o=0xA5, count_o=1.
- DEPTH=16: 16 writes 0x00..0x0F with m_ready_i=0, then 17th write 0x10 -> first 16 ack; 17th rty; count_o=16; FIFO head still 0x00.
- Fill 16, raise m_ready_i -> stream emits 0x00..0x0F on 16 consecutive cycles in order, then m_valid_o=0, count_o=0.
- Count 3, read cycle with ALLOW_READ=1 -> ack, wb_dat_o=0x03, count unchanged. Same read with ALLOW_READ=0 -> err, wb_dat_o=0x00.
- Full FIFO, write request sampled on the same edge as a stream pop -> rty, count goes 16->15. Retried write next IDLE -> ack, count back to 16.
- Assert rst_ni low during RESP with count=5 -> response outputs drop immediately, count_o=0, m_valid_o=0, FSM IDLE after release.

Source files
------------

// File: rtl/wb_stream_sink.sv
// Wishbone B4 classic byte sink: controller writes land in a FIFO that drains onto a
// valid/ready stream; reads report occupancy, and a full FIFO answers writes with retry.
`timescale 1ns/1ps
module wb_stream_sink #(
  parameter int unsigned DAT_WIDTH  = 8,
  parameter int unsigned DEPTH      = 16,
  parameter bit          ALLOW_READ = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [DAT_WIDTH-1:0]     wb_dat_i,
  output logic [DAT_WIDTH-1:0]     wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  output logic                     m_valid_o,
  output logic [DAT_WIDTH-1:0]     m_data_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t               r_state;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_rty;
  logic [DAT_WIDTH-1:0] r_dat;

  logic [DAT_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic                 w_req;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;

  assign w_req  = wb_cyc_i & wb_stb_i;
  // Full is judged on the registered count, so a pop on the same edge never makes room.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = (r_state == S_IDLE) & w_req & wb_we_i & ~w_full;
  assign w_pop  = (r_count != '0) & m_ready_i;

  // Bus FSM: a request is only sampled in IDLE, so every transfer takes at least two cycles
  // and no response line can be high on two consecutive cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      r_dat <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_RESP;
            if (wb_we_i) begin
              if (w_full) begin
                r_rty <= 1'b1;
              end else begin
                r_ack <= 1'b1;
              end
            end else if (ALLOW_READ) begin
              r_ack <= 1'b1;
              r_dat <= DAT_WIDTH'(r_count);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage carries no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wb_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign wb_rty_o  = r_rty;
  assign wb_dat_o  = r_dat;
  assign m_valid_o = (r_count != '0);
  assign m_data_o  = r_mem[r_rd_ptr];
  assign count_o   = r_count;

endmodule

// File: tb/tb_wb_stream_sink.sv
// Bench for wb_stream_sink: table-driven bus transfers, stream scoreboard, and hand-written
// sequences for full-with-pop, back-to-back drain and reset during a response.
`timescale 1ns/1ps
module tb_wb_stream_sink;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] RSP_ACK = 2'd0;
  localparam logic [1:0] RSP_RTY = 2'd2;

  typedef struct {
    logic          we;
    logic [DW-1:0] dat;
    logic [1:0]    rsp;
    logic [DW-1:0] rdat;
    logic [CW-1:0] cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic          m_ready = 1'b0;

  logic [DW-1:0] rdat, rdat_nr;
  logic          ack, err, rty, ack_nr, err_nr, rty_nr;
  logic          m_valid, m_valid_nr;
  logic [DW-1:0] m_data, m_data_nr;
  logic [CW-1:0] count, count_nr;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] sb[$];
  vec_t tbl[42];

  always #5 clk = ~clk;

  wb_stream_sink #(.DAT_WIDTH(DW), .DEPTH(DEPTH), .ALLOW_READ(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready), .count_o(count)
  );

  wb_stream_sink #(.DAT_WIDTH(DW), .DEPTH(DEPTH), .ALLOW_READ(1'b0)) dut_nr (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_dat_i(wdat), .wb_dat_o(rdat_nr), .wb_ack_o(ack_nr), .wb_err_o(err_nr), .wb_rty_o(rty_nr),
    .m_valid_o(m_valid_nr), .m_data_o(m_data_nr), .m_ready_i(m_ready), .count_o(count_nr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stream scoreboard: a pop happens on the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stream_pop: got %0h expected no data", m_data);
      end else begin
        chk("stream_data", m_data, sb.pop_front());
      end
    end
  end

  task automatic apply(input vec_t v, input string nm);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = v.we; wdat = v.dat;
    if (v.we && v.rsp == RSP_ACK) sb.push_back(v.dat);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk({nm, "_ack"}, ack, v.rsp == RSP_ACK);
    chk({nm, "_err"}, err, 1'b0);
    chk({nm, "_rty"}, rty, v.rsp == RSP_RTY);
    if (!v.we) chk({nm, "_rdat"}, rdat, v.rdat);
    chk({nm, "_count"}, count, v.cnt);
    chk({nm, "_nr_ack"}, ack_nr, v.we && v.rsp == RSP_ACK);
    chk({nm, "_nr_err"}, err_nr, !v.we);
    chk({nm, "_nr_rty"}, rty_nr, v.we && v.rsp == RSP_RTY);
    if (!v.we) chk({nm, "_nr_rdat"}, rdat_nr, 0);
    chk({nm, "_nr_count"}, count_nr, v.cnt);
    $display("xfer %s we=%0b dat=%0h ack=%0b err=%0b rty=%0b rdat=%0h count=%0d",
             nm, v.we, v.dat, ack, err, rty, rdat, count);
    @(posedge clk); #1;
    chk({nm, "_rsp_1cyc"}, {ack, err, rty, ack_nr, err_nr, rty_nr}, 0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(tbl[i], $sformatf("row%0d", i));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; m_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    // rows 0-1: single write then read
    tbl[0] = '{1'b1, 8'hA5, RSP_ACK, 8'h00, CW'(1)};
    tbl[1] = '{1'b0, 8'h00, RSP_ACK, 8'h01, CW'(1)};
    // rows 2-19: fill 0x00..0x0F, overflow write, read of full count
    for (int i = 0; i < 16; i++) tbl[2 + i] = '{1'b1, DW'(i), RSP_ACK, 8'h00, CW'(i + 1)};
    tbl[18] = '{1'b1, 8'h10, RSP_RTY, 8'h00, CW'(16)};
    tbl[19] = '{1'b0, 8'h00, RSP_ACK, 8'h10, CW'(16)};
    // rows 20-23: three writes then read of 3
    for (int i = 0; i < 3; i++) tbl[20 + i] = '{1'b1, DW'(8'h30 + i), RSP_ACK, 8'h00, CW'(i + 1)};
    tbl[23] = '{1'b0, 8'h00, RSP_ACK, 8'h03, CW'(3)};
    // rows 24-36: top up to full
    for (int i = 0; i < 13; i++) tbl[24 + i] = '{1'b1, DW'(8'h40 + i), RSP_ACK, 8'h00, CW'(i + 4)};
    // rows 37-41: five writes after a reset
    for (int i = 0; i < 5; i++) tbl[37 + i] = '{1'b1, DW'(8'h50 + i), RSP_ACK, 8'h00, CW'(i + 1)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp", {ack, err, rty, ack_nr, err_nr, rty_nr}, 0);
    chk("rst_rdat", rdat, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;

    run_rows(0, 1);
    chk("single_valid", m_valid, 1);
    chk("single_head", m_data, 8'hA5);

    m_ready = 1'b1;
    for (int k = 0; k < 10 && m_valid; k++) begin
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    chk("drain1_valid", m_valid, 0);
    chk("drain1_count", count, 0);

    run_rows(2, 19);
    chk("full_head", m_data, 8'h00);
    chk("full_valid", m_valid, 1);

    // back-to-back drain: valid must hold for 16 consecutive pops
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("drain16_valid%0d", k), m_valid, 1);
      chk($sformatf("drain16_head%0d", k), m_data, DW'(k));
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("drain16_empty", m_valid, 0);
    chk("drain16_count", count, 0);
    chk("drain16_sb", sb.size(), 0);

    run_rows(20, 23);
    run_rows(24, 36);

    // full FIFO: write sampled on the same edge as a pop still gets retry
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; wdat = 8'h60; m_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; m_ready = 1'b0;
    chk("fullpop_rty", rty, 1);
    chk("fullpop_ack", ack, 0);
    chk("fullpop_count", count, 15);
    $display("xfer fullpop we=1 dat=60 ack=%0b rty=%0b count=%0d", ack, rty, count);
    @(posedge clk); #1;
    chk("fullpop_rsp_1cyc", {ack, err, rty}, 0);
    v = '{1'b1, 8'h60, RSP_ACK, 8'h00, CW'(16)};
    apply(v, "retry");

    do_reset();
    chk("rst2_count", count, 0);
    run_rows(37, 41);

    // reset asserted while the read response is on the bus
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    chk("rstresp_ack_before", ack, 1);
    chk("rstresp_rdat_before", rdat, 5);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rstresp_rsp", {ack, err, rty, ack_nr, err_nr, rty_nr}, 0);
    chk("rstresp_rdat", rdat, 0);
    chk("rstresp_count", count, 0);
    chk("rstresp_valid", m_valid, 0);
    $display("xfer rst_in_resp ack=%0b count=%0d valid=%0b", ack, count, m_valid);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    v = '{1'b0, 8'h00, RSP_ACK, 8'h00, CW'(0)};
    apply(v, "post_rst_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200us");
    $fatal(1);
  end

endmodule
